qspi_device_interface: RTL and testbench
========================================

Name: qspi_device_interface

Overview:
- QSPI device-mode (target) transceiver: the far end of our QSPI host transceiver, for FPGA-as-flash-emulator and board-management target links.
- Oversamples external SCK/CS_N/DQ in the local clk domain, deserialises host bytes, serialises response bytes.
- SPI mode 0 only. Single-bit (DQ0 in, DQ1 out) and quad (DQ[3:0], one direction per byte) lanes.
- Parent logic supplies response bytes and consumes received bytes via pulse handshakes.

Parameters:
SYNC_STAGES, 2, synchroniser depth applied identically to qspi_sck, qspi_cs_n, qspi_dq_in (min 2)

Ports:
clk  input  1  system clock; must be >= 8x SCK frequency
rst_n  input  1  asynchronous active-low reset
qspi_sck  input  1  host serial clock (asynchronous)
qspi_cs_n  input  1  host chip select, active low (asynchronous)
qspi_dq_in  input  4  DQ pin inputs
qspi_dq_out  output  4  DQ pin output values
qspi_dq_tris  output  4  DQ tristate, 1 = high-Z
quad_en  input  1  next byte uses 4 lanes
quad_tx  input  1  when quad_en: 1 = device drives DQ[3:0], 0 = device receives
frame_start  output  1  pulse: CS_N asserted
frame_end  output  1  pulse: CS_N deasserted
rx_valid  output  1  pulse: rx_data holds a completed byte
rx_data  output  8  received byte, MSB first
tx_req  output  1  pulse: parent must present the next response byte on tx_data
tx_data  input  8  response byte; held stable from tx_req to next tx_req or frame_end

Behaviour:
- Reset: qspi_dq_out=0000, qspi_dq_tris=1111, all pulses 0, rx_data=00, state IDLE, bit counter 0.
- SCK, CS_N and DQ_in each pass through SYNC_STAGES flops, then one edge-detect register. Data is therefore time-aligned with detected edges. Pin-to-detected-edge latency = SYNC_STAGES+1 clk.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on detected CS_N fall:
  - frame_start and tx_req pulse in the same cycle.
  - quad_en/quad_tx are sampled to set the lane mode.
  - tx_data is loaded into the shift register on the following cycle.
  - Single mode: tris=1101, dq_out[1]=tx_data[7]. Quad tx: tris=0000, dq_out=tx_data[7:4]. Quad rx: tris=1111.
- ACTIVE, detected SCK rise:
  - Single mode: shift in DQ0, counter+1.
  - Quad rx: shift in DQ[3:0] nibble, counter+4.
  - Quad tx: counter+4, nothing captured.
- ACTIVE, detected SCK fall: drive the next bit (DQ1) or nibble (DQ[3:0]) from the shift register.
- Byte boundary: counter reaches 8 on a rise (3-bit counter wraps to 0).
  - rx_valid pulses with the assembled byte, except in quad-tx bytes.
  - tx_req pulses.
  - quad_en/quad_tx are re-sampled for the next byte.
  - At the next detected SCK fall, tx_data loads and its first bit/nibble is driven; tris updates to the new mode in the same cycle.
- The 8x clock ratio guarantees >= 3 clk between tx_req and that load.
- ACTIVE -> IDLE on detected CS_N rise, from any counter value:
  - frame_end pulses.
  - tris=1111 and dq_out=0000 the same cycle.
  - Partial byte discarded, no rx_valid. Counter cleared.
- SCK edges while IDLE are ignored.
- CS_N rise and SCK edge detected in the same cycle: CS_N wins; the edge is dropped.
- CS_N fall detected in the same cycle as frame_end is impossible (synchronised single signal); a glitch shorter than the sync window is filtered naturally.
- rx_valid and frame_end may coincide only when the byte completes on the cycle before CS_N rise is detected. Both assert in that case: rx_valid first cycle, frame_end next.
- rst_n assertion mid-frame returns immediately to reset values. After release, the block waits in IDLE for a fresh CS_N fall: a CS_N already low at release does not start a frame.

Optional Feature:
QSPI_DEVICE_BYTE_COUNT_EN
- Defined: adds output byte_count[15:0].
  - Cleared on frame_start.
  - Incremented at every byte boundary, including quad-tx bytes.
  - Saturates at FFFF.
  - Held after frame_end until the next frame.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single mode, host sends A5 with tx_data=3C -> one rx_valid with rx_data=A5; host samples 3C on DQ1; tris=1101 during frame, 1111 after frame_end.
- Command 6B single, then quad_en=1 quad_tx=1, tx_data=DE then AD -> rx_data=6B; host reads DQ[3:0] nibbles D,E,A,D; tris=0000 from first fall after boundary; two further tx_req pulses.
- Quad rx (quad_en=1 quad_tx=0), host drives nibbles 1,2,3,4 -> rx_valid twice with 12 then 34; tris stays 1111.
- CS_N deasserted after 5 bits of byte 2 -> frame_end pulse, only one rx_valid, counter 0; next frame's first byte 81 received intact.
- rst_n pulsed low mid-byte with CS_N held low -> outputs return to reset values immediately; no frame_start until CS_N rises and falls again.
- With QSPI_DEVICE_BYTE_COUNT_EN: 3-byte frame -> byte_count=3 after frame_end; reset to 0 at next frame_start.

Source files
------------

// File: rtl/qspi_device_interface_if.sv
// QSPI device-side bundle: host pins plus the parent byte handshake.
// The byte_count signal exists only when QSPI_DEVICE_BYTE_COUNT_EN is defined.
interface qspi_device_interface_if;
   logic        qspi_sck;
   logic        qspi_cs_n;
   logic [3:0]  qspi_dq_in;
   logic [3:0]  qspi_dq_out;
   logic [3:0]  qspi_dq_tris;
   logic        quad_en;
   logic        quad_tx;
   logic        frame_start;
   logic        frame_end;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_req;
   logic [7:0]  tx_data;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
   logic [15:0] byte_count;

   modport slave (
      input  qspi_sck, qspi_cs_n, qspi_dq_in, quad_en, quad_tx, tx_data,
      output qspi_dq_out, qspi_dq_tris, frame_start, frame_end,
             rx_valid, rx_data, tx_req, byte_count
   );

   modport master (
      output qspi_sck, qspi_cs_n, qspi_dq_in, quad_en, quad_tx, tx_data,
      input  qspi_dq_out, qspi_dq_tris, frame_start, frame_end,
             rx_valid, rx_data, tx_req, byte_count
   );
`else
   modport slave (
      input  qspi_sck, qspi_cs_n, qspi_dq_in, quad_en, quad_tx, tx_data,
      output qspi_dq_out, qspi_dq_tris, frame_start, frame_end,
             rx_valid, rx_data, tx_req
   );

   modport master (
      output qspi_sck, qspi_cs_n, qspi_dq_in, quad_en, quad_tx, tx_data,
      input  qspi_dq_out, qspi_dq_tris, frame_start, frame_end,
             rx_valid, rx_data, tx_req
   );
`endif
endinterface

// File: rtl/qspi_device_interface.sv
// QSPI device-mode (target) transceiver, SPI mode 0, single or quad lanes.
// External SCK/CS_N/DQ are oversampled in clk; clk must run at >= 8x SCK.
// Optional: define QSPI_DEVICE_BYTE_COUNT_EN to add a saturating per-frame
// byte counter (byte_count).
//
// state  | meaning
// IDLE   | CS_N high (or not yet seen falling since reset); pins high-Z
// ACTIVE | frame in progress; shifting bytes on detected SCK edges
module qspi_device_interface #(
   parameter int SYNC_STAGES = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   qspi_device_interface_if.slave bus
);

   typedef enum logic {IDLE, ACTIVE} state_t;
   typedef enum logic [1:0] {LANE_SINGLE, LANE_QTX, LANE_QRX} lane_t;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [3:0]             dq_sync [SYNC_STAGES];
   logic                   sck_prev;
   logic                   cs_prev;

   logic       sck_s, cs_s;
   logic [3:0] dq_s;
   logic       sck_rise, sck_fall, cs_rise, cs_fall;

   state_t     state;
   lane_t      lane;
   lane_t      next_lane;
   logic [2:0] bit_cnt;
   logic [2:0] cnt_step;
   logic [2:0] cnt_next;
   logic [7:0] shift_tx;
   logic [7:0] shift_rx;
   logic [7:0] rx_next;
   logic       load_first;
   logic       load_at_fall;
   logic [3:0] dq_out;
   logic [3:0] dq_tris;
   logic [3:0] load_out;
   logic [3:0] load_tris;
   logic [7:0] load_shift;
   logic       frame_start, frame_end, rx_valid, tx_req;
   logic [7:0] rx_data;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
   logic [15:0] byte_cnt;
`endif

   // Synchronise pins, then keep one delayed copy for edge detection.
   // CS_N flops reset low so a CS_N already low at release never looks like a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync <= '0;
         cs_sync  <= '0;
         sck_prev <= 1'b0;
         cs_prev  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) dq_sync[i] <= 4'h0;
      end else begin
         sck_sync   <= {sck_sync[SYNC_STAGES-2:0], bus.qspi_sck};
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.qspi_cs_n};
         dq_sync[0] <= bus.qspi_dq_in;
         for (int i = 1; i < SYNC_STAGES; i++) dq_sync[i] <= dq_sync[i-1];
         sck_prev   <= sck_sync[SYNC_STAGES-1];
         cs_prev    <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign dq_s     = dq_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign cs_rise  = cs_s & ~cs_prev;
   assign cs_fall  = ~cs_s & cs_prev;

   // Lane mode requested by the parent, per-edge counter step and assembled rx byte.
   always_comb begin
      next_lane = LANE_SINGLE;
      if (bus.quad_en) next_lane = bus.quad_tx ? LANE_QTX : LANE_QRX;
      cnt_step = (lane == LANE_SINGLE) ? 3'd1 : 3'd4;
      cnt_next = bit_cnt + cnt_step;
      rx_next  = (lane == LANE_SINGLE) ? {shift_rx[6:0], dq_s[0]}
                                       : {shift_rx[3:0], dq_s};
   end

   // Pin values and remaining shift bits when a fresh tx byte is loaded.
   always_comb begin
      load_out   = 4'b0000;
      load_tris  = 4'b1111;
      load_shift = bus.tx_data;
      case (lane)
         LANE_SINGLE: begin
            load_out   = {2'b00, bus.tx_data[7], 1'b0};
            load_tris  = 4'b1101;
            load_shift = {bus.tx_data[6:0], 1'b0};
         end
         LANE_QTX: begin
            load_out   = bus.tx_data[7:4];
            load_tris  = 4'b0000;
            load_shift = {bus.tx_data[3:0], 4'h0};
         end
         default: ;
      endcase
   end

   // Frame FSM: CS_N framing, bit/nibble shifting, byte boundaries, pin drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lane         <= LANE_SINGLE;
         bit_cnt      <= 3'd0;
         shift_tx     <= 8'h00;
         shift_rx     <= 8'h00;
         load_first   <= 1'b0;
         load_at_fall <= 1'b0;
         dq_out       <= 4'b0000;
         dq_tris      <= 4'b1111;
         frame_start  <= 1'b0;
         frame_end    <= 1'b0;
         rx_valid     <= 1'b0;
         rx_data      <= 8'h00;
         tx_req       <= 1'b0;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
         byte_cnt     <= 16'h0000;
`endif
      end else begin
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         rx_valid    <= 1'b0;
         tx_req      <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state       <= ACTIVE;
                  frame_start <= 1'b1;
                  tx_req      <= 1'b1;
                  lane        <= next_lane;
                  bit_cnt     <= 3'd0;
                  load_first  <= 1'b1;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
                  byte_cnt    <= 16'h0000;
`endif
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state        <= IDLE;
                  frame_end    <= 1'b1;
                  dq_out       <= 4'b0000;
                  dq_tris      <= 4'b1111;
                  bit_cnt      <= 3'd0;
                  load_first   <= 1'b0;
                  load_at_fall <= 1'b0;
               end else if (load_first) begin
                  // tx_data is valid in the tx_req cycle, which is this one
                  load_first <= 1'b0;
                  dq_out     <= load_out;
                  dq_tris    <= load_tris;
                  shift_tx   <= load_shift;
               end else if (sck_rise) begin
                  bit_cnt  <= cnt_next;
                  shift_rx <= (lane == LANE_QTX) ? shift_rx : rx_next;
                  if (cnt_next == 3'd0) begin
                     rx_valid     <= (lane != LANE_QTX);
                     rx_data      <= (lane == LANE_QTX) ? rx_data : rx_next;
                     tx_req       <= 1'b1;
                     lane         <= next_lane;
                     load_at_fall <= 1'b1;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
                     if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
`endif
                  end
               end else if (sck_fall) begin
                  if (load_at_fall) begin
                     load_at_fall <= 1'b0;
                     dq_out       <= load_out;
                     dq_tris      <= load_tris;
                     shift_tx     <= load_shift;
                  end else if (lane == LANE_SINGLE) begin
                     dq_out   <= {2'b00, shift_tx[7], 1'b0};
                     shift_tx <= {shift_tx[6:0], 1'b0};
                  end else if (lane == LANE_QTX) begin
                     dq_out   <= shift_tx[7:4];
                     shift_tx <= {shift_tx[3:0], 4'h0};
                  end
               end
            end
         endcase
      end
   end

   assign bus.qspi_dq_out  = dq_out;
   assign bus.qspi_dq_tris = dq_tris;
   assign bus.frame_start  = frame_start;
   assign bus.frame_end    = frame_end;
   assign bus.rx_valid     = rx_valid;
   assign bus.rx_data      = rx_data;
   assign bus.tx_req       = tx_req;
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
   assign bus.byte_count   = byte_cnt;
`endif

endmodule

// File: tb/tb_qspi_device_interface.sv
// Bench for qspi_device_interface: a host model toggles pins with random
// SCK half-periods; expected rx bytes, tx bytes seen on DQ, tris values and
// pulse counts come from the byte/mode description of each frame.
`timescale 1ns/1ps
module tb_qspi_device_interface;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qspi_device_interface_if bus ();

   qspi_device_interface #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int n_fs = 0, n_fe = 0, n_txreq = 0, n_rx = 0;
   logic [7:0] last_rx = 8'h00;
   bit idle_chk = 1'b0;

   // frame description: mode per byte (0 single, 1 quad tx, 2 quad rx)
   int         md [8];
   logic [7:0] hv [8];
   logic [7:0] tv [8];
   logic [7:0] cap [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input int m);
      case (m)
         0:       begin bus.quad_en = 1'b0; bus.quad_tx = 1'($urandom); end
         1:       begin bus.quad_en = 1'b1; bus.quad_tx = 1'b1; end
         default: begin bus.quad_en = 1'b1; bus.quad_tx = 1'b0; end
      endcase
   endtask

   // Compare process: pulses, rx scoreboard, tx_data supply, idle pin state.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.tx_data = 8'h00;
      end else begin
         if (bus.frame_start) n_fs++;
         if (bus.frame_end) n_fe++;
         if (bus.tx_req) begin
            n_txreq++;
            if (txq.size() > 0) bus.tx_data = txq.pop_front();
            else bus.tx_data = 8'($urandom);
         end
         if (bus.rx_valid) begin
            n_rx++;
            last_rx = bus.rx_data;
            if (rxq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rx_unexpected: got rx_data %0h with no byte expected at %0t",
                        bus.rx_data, $time);
            end else begin
               check("rx_data", bus.rx_data, rxq.pop_front());
            end
         end
         if (idle_chk) begin
            check("idle_tris", bus.qspi_dq_tris, 4'hF);
            check("idle_dq_out", bus.qspi_dq_out, 4'h0);
         end
      end
   end

   // Host: nfull complete bytes, then optionally 'part' units of one more byte.
   task automatic run_frame(input int nfull, input int part);
      int fs0, fe0, tr0, nb, half, units, send;
      logic [3:0] exp_n;
      fs0  = n_fs;
      fe0  = n_fe;
      tr0  = n_txreq;
      nb   = nfull + ((part > 0) ? 1 : 0);
      half = $urandom_range(5, 8);
      txq.delete();
      for (int b = 0; b < nb; b++) txq.push_back(tv[b]);
      for (int b = 0; b < 8; b++) cap[b] = 8'h00;
      set_mode(md[0]);
      idle_chk = 1'b0;
      bus.qspi_cs_n = 1'b0;
      tick(10);
      check("frame_start", n_fs - fs0, 1);
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
      check("byte_count_clear", bus.byte_count, 0);
`endif
      for (int b = 0; b < nb; b++) begin
         units = (md[b] == 0) ? 8 : 2;
         send  = (b == nfull) ? part : units;
         for (int u = 0; u < send; u++) begin
            if (md[b] == 0) bus.qspi_dq_in = {3'($urandom), hv[b][7-u]};
            else if (md[b] == 2) bus.qspi_dq_in = (u == 0) ? hv[b][7:4] : hv[b][3:0];
            else bus.qspi_dq_in = 4'($urandom);
            if (u == send - 1 && b + 1 < nb) set_mode(md[b+1]);
            tick(half);
            bus.qspi_sck = 1'b1;
            if (md[b] == 0) begin
               check("tris_single", bus.qspi_dq_tris, 4'b1101);
               check("dq1_bit", bus.qspi_dq_out[1], tv[b][7-u]);
               cap[b][7-u] = bus.qspi_dq_out[1];
            end else if (md[b] == 1) begin
               exp_n = (u == 0) ? tv[b][7:4] : tv[b][3:0];
               check("tris_qtx", bus.qspi_dq_tris, 4'b0000);
               check("dq_nibble", bus.qspi_dq_out, exp_n);
               if (u == 0) cap[b][7:4] = bus.qspi_dq_out;
               else cap[b][3:0] = bus.qspi_dq_out;
            end else begin
               check("tris_qrx", bus.qspi_dq_tris, 4'b1111);
            end
            if (u == units - 1 && md[b] != 1) rxq.push_back(hv[b]);
            tick(half);
            bus.qspi_sck = 1'b0;
         end
      end
      tick(half);
      bus.qspi_cs_n = 1'b1;
      tick(8);
      check("frame_end", n_fe - fe0, 1);
      check("tx_req_count", n_txreq - tr0, nfull + 1);
      check("rx_pending", rxq.size(), 0);
      check("end_tris", bus.qspi_dq_tris, 4'hF);
      check("end_dq_out", bus.qspi_dq_out, 4'h0);
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
      check("byte_count", bus.byte_count, nfull);
`endif
      idle_chk = 1'b1;
      tick(4);
   endtask

   initial begin
      #800us;
      $display("FAIL timeout: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int fs0, nfull, part;
      bus.qspi_sck   = 1'b0;
      bus.qspi_cs_n  = 1'b1;
      bus.qspi_dq_in = 4'h0;
      bus.quad_en    = 1'b0;
      bus.quad_tx    = 1'b0;
      tick(3);
      check("rst_dq_out", bus.qspi_dq_out, 4'h0);
      check("rst_tris", bus.qspi_dq_tris, 4'hF);
      check("rst_pulses", {bus.frame_start, bus.frame_end, bus.rx_valid, bus.tx_req}, 4'h0);
      check("rst_rx_data", bus.rx_data, 8'h00);
      rst_n = 1'b1;
      tick(6);
      idle_chk = 1'b1;

      // single byte: host sends A5, device answers 3C
      md = '{0, 0, 0, 0, 0, 0, 0, 0};
      hv[0] = 8'hA5; tv[0] = 8'h3C;
      run_frame(1, 0);
      check("lit_rx_A5", last_rx, 8'hA5);
      check("lit_host_3C", cap[0], 8'h3C);

      // command 6B then two quad-tx bytes DE, AD
      md = '{0, 1, 1, 0, 0, 0, 0, 0};
      hv[0] = 8'h6B; hv[1] = 8'h00; hv[2] = 8'h00;
      tv[0] = 8'hFF; tv[1] = 8'hDE; tv[2] = 8'hAD;
      fs0 = n_rx;
      run_frame(3, 0);
      check("lit_rx_6B", last_rx, 8'h6B);
      check("lit_rx_count_6B", n_rx - fs0, 1);
      check("lit_host_DE", cap[1], 8'hDE);
      check("lit_host_AD", cap[2], 8'hAD);
`ifdef QSPI_DEVICE_BYTE_COUNT_EN
      check("lit_byte_count_3", bus.byte_count, 16'd3);
`endif

      // quad rx: nibbles 1,2,3,4
      md = '{2, 2, 0, 0, 0, 0, 0, 0};
      hv[0] = 8'h12; hv[1] = 8'h34;
      fs0 = n_rx;
      run_frame(2, 0);
      check("lit_rx_34", last_rx, 8'h34);
      check("lit_rx_count_quad", n_rx - fs0, 2);

      // abort after 5 bits of byte 2, then 81 in a fresh frame
      md = '{0, 0, 0, 0, 0, 0, 0, 0};
      hv[0] = 8'hC3; hv[1] = 8'hF0; tv[0] = 8'h5A; tv[1] = 8'h96;
      fs0 = n_rx;
      run_frame(1, 5);
      check("lit_rx_count_abort", n_rx - fs0, 1);
      hv[0] = 8'h81; tv[0] = 8'h18;
      run_frame(1, 0);
      check("lit_rx_81", last_rx, 8'h81);

      // reset mid-byte with CS_N held low
      idle_chk = 1'b0;
      txq.delete();
      txq.push_back(8'hE7);
      set_mode(0);
      bus.qspi_cs_n = 1'b0;
      tick(10);
      for (int u = 0; u < 3; u++) begin
         bus.qspi_dq_in = 4'($urandom);
         tick(6);
         bus.qspi_sck = 1'b1;
         tick(6);
         bus.qspi_sck = 1'b0;
      end
      tick(2);
      rst_n = 1'b0;
      #1;
      check("midrst_dq_out", bus.qspi_dq_out, 4'h0);
      check("midrst_tris", bus.qspi_dq_tris, 4'hF);
      check("midrst_pulses", {bus.frame_start, bus.frame_end, bus.rx_valid, bus.tx_req}, 4'h0);
      check("midrst_rx_data", bus.rx_data, 8'h00);
      tick(3);
      rst_n = 1'b1;
      fs0 = n_fs;
      tick(4);
      for (int u = 0; u < 3; u++) begin
         tick(6);
         bus.qspi_sck = 1'b1;
         tick(6);
         bus.qspi_sck = 1'b0;
      end
      tick(6);
      check("no_frame_after_rst", n_fs - fs0, 0);
      check("postrst_tris", bus.qspi_dq_tris, 4'hF);
      bus.qspi_cs_n = 1'b1;
      tick(8);
      idle_chk = 1'b1;
      hv[0] = 8'h4D; tv[0] = 8'hB2;
      run_frame(1, 0);
      check("lit_rx_4D", last_rx, 8'h4D);

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         nfull = $urandom_range(1, 4);
         for (int b = 0; b < 8; b++) begin
            md[b] = $urandom_range(0, 2);
            hv[b] = 8'($urandom);
            tv[b] = 8'($urandom);
         end
         part = 0;
         if ($urandom_range(0, 3) == 0) part = (md[nfull] == 0) ? $urandom_range(1, 7) : 1;
         run_frame(nfull, part);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
